// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back path.
//   XLEN, AW, NREQ_WB : default data width, address width, requester count
//   WB_ALU/LOAD/DBG   : requester index assignment on the write-back arbiter
//   wb_port_t         : register-file write-port bundle (we, addr, data)
package rf_pkg;
  localparam int XLEN    = 32;
  localparam int AW      = 5;
  localparam int NREQ_WB = 3;

  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_DBG  = 2;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_port_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal priority pointer.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   req        : request vector
//   advance    : a grant was accepted; move the pointer past the winner
//   grant      : one-hot grant (zero when no request), combinational
//   winner     : index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N-1:0]                  req,
  input  logic                          advance,
  output logic [N-1:0]                  grant,
  output logic [((N>1)?$clog2(N):1)-1:0] winner
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] r_ptr;
  logic         w_found;
  logic [W:0]   w_sum;
  logic [W-1:0] w_idx;

  // Search ptr, ptr+1, ... wrapping at N. ptr and k are both < N, so one
  // conditional subtract is enough for the modulo.
  always_comb begin
    grant   = '0;
    winner  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (W+1)'(k);
      if (w_sum >= (W+1)'(N)) w_sum = w_sum - (W+1)'(N);
      w_idx = w_sum[W-1:0];
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        grant[w_idx] = 1'b1;
        winner       = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        r_ptr <= '0;
    else if (advance) r_ptr <= (int'(winner) == N-1) ? '0 : winner + W'(1);
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port.
// Requesters (0 = ALU, 1 = load, 2 = debug) compete round-robin; the winner's
// address/data are registered onto the write port, so the register file sees
// at most one clean write per cycle, one cycle after the handshake.
// Writes to x0 complete the handshake but never raise reg_write.
//
// Optional macro RF_SCOREBOARD_EN: builds a per-register busy scoreboard
// (set by alloc, cleared by a committing write, set wins on collision).
// Without it busy1/busy2 are 0 and the alloc/chk inputs are ignored.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/addr/data : per-requester write (addr/data flattened by index)
//   req_ready           : one-hot grant, combinational from req_valid + ptr
//   reg_write/write_reg/write_data : registered register-file write port
//   alloc_valid/alloc_reg : mark a register as having a pending write
//   chk_reg1/2, busy1/2 : combinational pending-write lookup
module regfile_wb_arbiter #(
  parameter int NREQ = rf_pkg::NREQ_WB,
  parameter int XLEN = rf_pkg::XLEN,
  parameter int AW   = rf_pkg::AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 reg_write,
  output logic [AW-1:0]        write_reg,
  output logic [XLEN-1:0]      write_data,
  input  logic                 alloc_valid,
  input  logic [AW-1:0]        alloc_reg,
  input  logic [AW-1:0]        chk_reg1,
  input  logic [AW-1:0]        chk_reg2,
  output logic                 busy1,
  output logic                 busy2
);
  localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] w_grant;
  logic [WW-1:0]   w_win;
  logic            w_xfer;
  logic [AW-1:0]   w_addr;
  logic [XLEN-1:0] w_data;

  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wdata;

  // Every grant is a transfer since grants only go to valid requesters.
  assign req_ready = reset ? '0 : w_grant;
  assign w_xfer    = |req_ready;
  assign w_addr    = req_addr[w_win*AW +: AW];
  assign w_data    = req_data[w_win*XLEN +: XLEN];

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (w_xfer),
    .grant   (w_grant),
    .winner  (w_win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_xfer) begin
      r_we    <= (w_addr != '0);
      r_waddr <= w_addr;
      r_wdata <= w_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign reg_write  = r_we;
  assign write_reg  = r_waddr;
  assign write_data = r_wdata;

`ifdef RF_SCOREBOARD_EN
  logic [2**AW-1:0] r_busy;

  // Clear first, set second: the later assignment wins when both hit the
  // same register. r_waddr is never 0 while r_we is high, and x0 allocs are
  // dropped, so r_busy[0] stays 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (r_we) r_busy[r_waddr] <= 1'b0;
      if (alloc_valid && alloc_reg != '0) r_busy[alloc_reg] <= 1'b1;
    end
  end

  assign busy1 = r_busy[chk_reg1];
  assign busy2 = r_busy[chk_reg2];
`else
  logic w_unused;
  assign w_unused = ^{alloc_valid, alloc_reg, chk_reg1, chk_reg2};
  assign busy1    = 1'b0;
  assign busy2    = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [14:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_ready;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_reg = '0;
  logic [4:0]  chk_reg1 = '0;
  logic [4:0]  chk_reg2 = '0;
  logic        busy1, busy2;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data), .alloc_valid(alloc_valid),
    .alloc_reg(alloc_reg), .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .busy1(busy1), .busy2(busy2)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  typedef struct { int due; logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [2:0] g; logic b1; logic b2; } cy_t;
  wr_t wq[$];
  cy_t cq[$];

  // Values applied by the next cyc() call
  logic [4:0]  na[3];
  logic [31:0] nd[3];
  logic        nalloc = 1'b0;
  logic [4:0]  nalloc_r = '0, nc1 = '0, nc2 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cnt, act, exp);
    end
  endtask

  // One cycle of stimulus with its hand-computed grant and busy expectations.
  task automatic cyc(input logic [2:0] v, input logic r, input logic [2:0] eg,
                     input logic eb1, input logic eb2);
    @(posedge clk); #1;
    reset       = r;
    req_valid   = v;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*5 +: 5]  = na[i];
      req_data[i*32 +: 32] = nd[i];
    end
    alloc_valid = nalloc;
    alloc_reg   = nalloc_r;
    chk_reg1    = nc1;
    chk_reg2    = nc2;
    cq.push_back('{eg, eb1 & SB, eb2 & SB});
    if (!r)
      for (int i = 0; i < 3; i++)
        if (eg[i] && na[i] != 5'd0) wq.push_back('{cnt + 1, na[i], nd[i]});
  endtask

  // Monitor: grants/busy every cycle, and the write port against the queue.
  always @(negedge clk) begin
    cy_t e;
    wr_t w;
    logic exp_we;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      chk("req_ready", 32'(req_ready), 32'(e.g));
      chk("busy1", 32'(busy1), 32'(e.b1));
      chk("busy2", 32'(busy2), 32'(e.b2));
    end
    if (mon_en) begin
      exp_we = (wq.size() > 0) && (wq[0].due == cnt);
      chk("reg_write", 32'(reg_write), 32'(exp_we));
      if (exp_we) begin
        w = wq.pop_front();
        chk("write_reg", 32'(write_reg), 32'(w.a));
        chk("write_data", write_data, w.d);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin na[i] = '0; nd[i] = '0; end

    // Reset
    cyc(3'b000, 1'b1, 3'b000, 0, 0);
    mon_en = 1'b1;
    cyc(3'b000, 1'b1, 3'b000, 0, 0);
    @(negedge clk);
    chk("rst_write_reg", 32'(write_reg), 32'd0);
    chk("rst_write_data", write_data, 32'd0);

    // Single request from the ALU
    na[0] = 5'd5; nd[0] = 32'hDEAD_BEEF;
    cyc(3'b001, 1'b0, 3'b001, 0, 0);
    cyc(3'b000, 1'b0, 3'b000, 0, 0);
    cyc(3'b000, 1'b0, 3'b000, 0, 0);

    // Fairness from ptr = 0
    cyc(3'b000, 1'b1, 3'b000, 0, 0);
    na[0] = 5'd1; na[1] = 5'd2; na[2] = 5'd3;
    nd[0] = 32'h11; nd[1] = 32'h22; nd[2] = 32'h33;
    cyc(3'b111, 1'b0, 3'b001, 0, 0);
    cyc(3'b111, 1'b0, 3'b010, 0, 0);
    cyc(3'b111, 1'b0, 3'b100, 0, 0);
    cyc(3'b111, 1'b0, 3'b001, 0, 0);
    cyc(3'b111, 1'b0, 3'b010, 0, 0);
    cyc(3'b111, 1'b0, 3'b100, 0, 0);
    cyc(3'b000, 1'b0, 3'b000, 0, 0);

    // x0 suppression; pointer must move to 2
    na[1] = 5'd0; nd[1] = 32'h0000_000C;
    cyc(3'b010, 1'b0, 3'b010, 0, 0);
    cyc(3'b111, 1'b0, 3'b100, 0, 0);
    cyc(3'b000, 1'b0, 3'b000, 0, 0);
    na[1] = 5'd2;

    // Scoreboard: alloc, commit clears, same-edge set wins
    nc1 = 5'd7; nalloc = 1'b1; nalloc_r = 5'd7;
    cyc(3'b000, 1'b0, 3'b000, 0, 0);
    nalloc = 1'b0;
    cyc(3'b000, 1'b0, 3'b000, 1, 0);
    na[0] = 5'd7; nd[0] = 32'h77;
    cyc(3'b001, 1'b0, 3'b001, 1, 0);
    cyc(3'b000, 1'b0, 3'b000, 1, 0);
    cyc(3'b000, 1'b0, 3'b000, 0, 0);
    nalloc = 1'b1;
    cyc(3'b000, 1'b0, 3'b000, 0, 0);
    nalloc = 1'b0;
    cyc(3'b001, 1'b0, 3'b001, 1, 0);
    nalloc = 1'b1;
    cyc(3'b000, 1'b0, 3'b000, 1, 0);
    nalloc = 1'b0;
    cyc(3'b000, 1'b0, 3'b000, 1, 0);
    // alloc of x0 is ignored
    nalloc = 1'b1; nalloc_r = 5'd0; nc2 = 5'd0;
    cyc(3'b000, 1'b0, 3'b000, 1, 0);
    nalloc = 1'b0;
    cyc(3'b000, 1'b0, 3'b000, 1, 0);
    // r4 lookup (always 0 when the scoreboard is not built)
    nc1 = 5'd4; nalloc = 1'b1; nalloc_r = 5'd4;
    cyc(3'b000, 1'b0, 3'b000, 0, 0);
    nalloc = 1'b0;
    cyc(3'b000, 1'b0, 3'b000, 1, 0);

    // Reset mid-stream, one cycle after a handshake
    nc2 = 5'd9; nalloc = 1'b1; nalloc_r = 5'd9;
    cyc(3'b000, 1'b0, 3'b000, 1, 0);
    nalloc = 1'b0; na[0] = 5'd8; nd[0] = 32'h88;
    cyc(3'b001, 1'b0, 3'b001, 1, 1);
    na[0] = 5'd1; nd[0] = 32'h11;
    cyc(3'b111, 1'b1, 3'b000, 1, 1);
    cyc(3'b111, 1'b0, 3'b001, 0, 0);
    cyc(3'b000, 1'b0, 3'b000, 0, 0);
    cyc(3'b000, 1'b0, 3'b000, 0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("cq_drained", 32'(cq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port among several write-back requesters (ALU, load unit, debug/CSR path) using round-robin arbitration and a valid/ready handshake. It drives the register file write inputs from registered outputs, so the register file sees one clean write per cycle. It optionally keeps a per-register busy scoreboard so issue logic can stall on pending writes.

## Interface
- NREQ, 3, number of write-back requesters; index 0 = ALU, 1 = load, 2 = debug
- XLEN, 32, data width
- AW, 5, register address width; 2**AW registers
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset; **one clock; reset is synchronous and active-high**
- req_valid  in  NREQ  requester i holds a write
- req_addr  in  NREQ*AW  destination of requester i, slice [i*AW +: AW]
- req_data  in  NREQ*XLEN  data of requester i, slice [i*XLEN +: XLEN]
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
- reg_write  out  1  register file write enable (registered)
- write_reg  out  AW  register file write address (registered)
- write_data  out  XLEN  register file write data (registered)
- alloc_valid  in  1  issue logic marks alloc_reg as having a pending write
- alloc_reg  in  AW  register being allocated
- chk_reg1, chk_reg2  in  AW each  source registers to check
- busy1, busy2  out  1 each  pending-write status of chk_reg1/chk_reg2 (combinational)

## Operation
- Round-robin pointer ptr (0..NREQ-1). Each cycle, grant the first i with req_valid[i], searching ptr, ptr+1, … mod NREQ.
- req_ready is one-hot or zero. It is zero when no requester is valid. It is combinational from req_valid and ptr. Requesters must not derive req_valid from req_ready.
- On a transfer by requester w: ptr <= (w+1) mod NREQ. Capture addr/data of w into the output registers. Set reg_write <= 1, except when addr = 0: the transfer completes but reg_write <= 0, so x0 is never written.
- No transfer: reg_write <= 0. write_reg and write_data hold their previous values.
- A requester holds addr/data stable while valid and not granted. A requester may drop valid without a transfer.
- Scoreboard busy[2**AW]:
  - alloc_valid with alloc_reg != 0 sets busy[alloc_reg].
  - An edge where reg_write = 1 clears busy[write_reg].
  - If set and clear target the same register in the same cycle, the set wins.
  - alloc of x0 is ignored, so busy[0] is always 0.
- busy1 = busy[chk_reg1] and busy2 = busy[chk_reg2]. These read the current state, so a write committing this cycle still shows busy.

## Timing
- Reset values: reg_write = 0, write_reg = 0, write_data = 0, ptr = 0, all busy = 0. req_ready = 0 while reset is high.
- Reset mid-operation: pending grants are dropped and any registered write is cancelled. Requesters re-present after reset.
- Latency: handshake on edge N puts the write on reg_write/write_reg/write_data during cycle N+1. The register file writes it at edge N+1.
- Throughput: one write per cycle. If all NREQ requesters stay valid, each is granted once every NREQ cycles.
- Worst-case wait: NREQ-1 cycles from assertion of valid to grant.

## Configuration
- RF_SCOREBOARD_EN defined: the busy array and its set/clear logic are built as described.
- RF_SCOREBOARD_EN undefined: no busy storage. busy1 and busy2 are tied 0, and alloc_valid, alloc_reg, chk_reg1 and chk_reg2 are ignored.
- Ports are identical in both builds.

## Structure
- Shared package `rf_pkg` holds:
  - constants XLEN, AW, NREQ_WB;
  - requester index constants WB_ALU = 0, WB_LOAD = 1, WB_DBG = 2;
  - a typedef for the write-port bundle (we, addr, data).
- One sub-module, `rr_arbiter`, is parameterized by N. It has inputs req[N] and advance, and outputs a one-hot grant[N] and the winner index. It holds ptr internally.
- The top module contains the output registers and the scoreboard.

## Test plan
- Single request: reset, then req_valid = 3'b001, addr = 5, data = 0xDEAD_BEEF, held for one cycle.
  - req_ready = 001 in that cycle.
  - Next cycle: reg_write = 1, write_reg = 5, write_data = 0xDEADBEEF.
  - Following cycle: reg_write = 0.
- Fairness: all three requesters continuously valid with addrs 1/2/3 for 6 cycles.
  - Grant order is 0, 1, 2, 0, 1, 2.
  - write_reg sequence is 1, 2, 3, 1, 2, 3 with one-cycle lag.
- x0 suppression: requester 1 writes addr 0, data 0x0000_000C.
  - Handshake completes (req_ready[1] = 1).
  - reg_write stays 0 the next cycle, and ptr advances to 2.
- Scoreboard (RF_SCOREBOARD_EN):
  - alloc r7 → busy1 = 1 for chk_reg1 = 7 on the next cycle.
  - A write to r7 commits → busy1 = 0 the cycle after reg_write.
  - alloc r7 on the same edge as the commit → busy1 stays 1.
- Reset mid-stream: assert reset on the cycle after a handshake.
  - reg_write = 0, ptr = 0 and all busy = 0 after the reset edge.
  - Next grant goes to the lowest valid index.
- Build without RF_SCOREBOARD_EN: alloc r4 with chk_reg1 = 4 → busy1 = 0 at all times.
